// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, default geometry and request record for the data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_DATA_W  = 64;
  localparam int DMEM_ADDR_W  = 64;
  localparam int DMEM_MEMSIZE = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant, combinational while en is high; zero latency.
// On a tie the port that did not win last time is granted; last_grant resets to port 1.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)        last_grant <= 1'b1;
    else if (|gnt)   last_grant <= gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end to the data memory; accept T, access T+1, response T+2.
// Ready only in IDLE, no response backpressure. DMEM_ARB_PERF_EN adds saturating perf counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int MEMSIZE = DMEM_MEMSIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_write,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_write,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_err
`endif
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEMSIZE);

  state_t     state;
  logic [1:0] gnt;
  logic       owner_q;
  logic       err_q;
  logic       mem_wr_q;
  logic       mem_rd_q;
  req_t       sel;
  logic       sel_err;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  ((state == IDLE) && rst),
    .req ({p1_req_valid, p0_req_valid}),
    .gnt (gnt)
  );

  assign p0_req_ready = gnt[0];
  assign p1_req_ready = gnt[1];

  always_comb begin
    if (gnt[1]) begin
      sel.write = p1_req_write;
      sel.addr  = p1_req_addr;
      sel.wdata = p1_req_wdata;
    end else begin
      sel.write = p0_req_write;
      sel.addr  = p0_req_addr;
      sel.wdata = p0_req_wdata;
    end
    sel_err = (sel.addr >= LIMIT);
  end

  // Strobes are also gated by rst so a reset landing in ACCESS cannot commit a store.
  assign mem_write = mem_wr_q & rst;
  assign mem_read  = mem_rd_q & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      p0_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_rdata <= '0;
      p1_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner_q   <= gnt[1];
            err_q     <= sel_err;
            mem_addr  <= sel.addr;
            mem_wdata <= sel.wdata;
            mem_wr_q  <= sel.write & ~sel_err;
            mem_rd_q  <= ~sel.write & ~sel_err;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wr_q     <= 1'b0;
          mem_rd_q     <= 1'b0;
          mem_addr     <= '0;
          mem_wdata    <= '0;
          // Load data is captured straight into the owner's response register.
          p0_rsp_valid <= ~owner_q;
          p0_rsp_err   <= ~owner_q & err_q;
          p0_rsp_rdata <= (~owner_q & mem_rd_q) ? mem_rdata : '0;
          p1_rsp_valid <= owner_q;
          p1_rsp_err   <= owner_q & err_q;
          p1_rsp_rdata <= (owner_q & mem_rd_q) ? mem_rdata : '0;
          state        <= RESP;
        end
        RESP: begin
          p0_rsp_valid <= 1'b0;
          p0_rsp_rdata <= '0;
          p0_rsp_err   <= 1'b0;
          p1_rsp_valid <= 1'b0;
          p1_rsp_rdata <= '0;
          p1_rsp_err   <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
      perf_err      <= '0;
    end else begin
      if (gnt[0] && perf_grant0 != 32'hFFFF_FFFF) perf_grant0 <= perf_grant0 + 32'd1;
      if (gnt[1] && perf_grant1 != 32'hFFFF_FFFF) perf_grant1 <= perf_grant1 + 32'd1;
      if (state == IDLE && p0_req_valid && p1_req_valid && perf_conflict != 32'hFFFF_FFFF)
        perf_conflict <= perf_conflict + 32'd1;
      if ((|gnt) && sel_err && perf_err != 32'hFFFF_FFFF) perf_err <= perf_err + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked every cycle against
// a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int MS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          p0_req_valid, p0_req_ready, p0_req_write;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata;
  logic          p0_rsp_valid, p0_rsp_err;
  logic [DW-1:0] p0_rsp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_write;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata;
  logic          p1_rsp_valid, p1_rsp_err;
  logic [DW-1:0] p1_rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write, mem_read;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_grant0, perf_grant1, perf_conflict, perf_err;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
    .perf_conflict(perf_conflict), .perf_err(perf_err)
`endif
  );

  // The data memory itself: asynchronous read, write on the rising edge.
  logic [DW-1:0] dmem [MS] = '{default: '0};
  always @(posedge clk) if (mem_write && mem_addr < AW'(MS)) dmem[mem_addr[5:0]] <= mem_wdata;
  assign mem_rdata = (mem_addr < AW'(MS)) ? dmem[mem_addr[5:0]] : '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_write) wr_cnt++;
    if (mem_read) rd_cnt++;
    if (p0_rsp_valid || p1_rsp_valid) rsp_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: one access slot and one response slot ----------------
  logic [DW-1:0] ref_mem [MS] = '{default: '0};
  bit            last_g = 1'b1;
  bit            a_pend = 1'b0, a_port, a_wr, a_err;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  bit            r_pend = 1'b0, r_port, r_err;
  logic [DW-1:0] r_rdata;
  bit            m_acc0 = 1'b0, m_acc1 = 1'b0;

  always @(negedge clk) begin
    bit            idle, e_rdy0, e_rdy1, e_w, e_r;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    idle   = !a_pend && !r_pend;
    e_rdy0 = 1'b0;
    e_rdy1 = 1'b0;
    if (idle && rst) begin
      if (p0_req_valid && p1_req_valid) begin
        if (last_g) e_rdy0 = 1'b1; else e_rdy1 = 1'b1;
      end else begin
        e_rdy0 = p0_req_valid;
        e_rdy1 = p1_req_valid;
      end
    end
    e_addr = a_pend ? a_addr : '0;
    e_wd   = a_pend ? a_wdata : '0;
    e_w    = a_pend && a_wr && !a_err && rst;
    e_r    = a_pend && !a_wr && !a_err && rst;
    check("p0_req_ready", p0_req_ready, e_rdy0);
    check("p1_req_ready", p1_req_ready, e_rdy1);
    check("mem_write", mem_write, e_w);
    check("mem_read", mem_read, e_r);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("p0_rsp_valid", p0_rsp_valid, r_pend && !r_port);
    check("p0_rsp_rdata", p0_rsp_rdata, (r_pend && !r_port) ? r_rdata : 64'd0);
    check("p0_rsp_err", p0_rsp_err, r_pend && !r_port && r_err);
    check("p1_rsp_valid", p1_rsp_valid, r_pend && r_port);
    check("p1_rsp_rdata", p1_rsp_rdata, (r_pend && r_port) ? r_rdata : 64'd0);
    check("p1_rsp_err", p1_rsp_err, r_pend && r_port && r_err);

    m_acc0 = e_rdy0 && p0_req_valid;
    m_acc1 = e_rdy1 && p1_req_valid;
    if (!rst) begin
      a_pend = 1'b0;
      r_pend = 1'b0;
      last_g = 1'b1;
    end else begin
      r_pend = a_pend;
      if (a_pend) begin
        r_port  = a_port;
        r_err   = a_err;
        r_rdata = (!a_wr && !a_err) ? ref_mem[a_addr[5:0]] : '0;
        if (a_wr && !a_err) ref_mem[a_addr[5:0]] = a_wdata;
      end
      a_pend = m_acc0 || m_acc1;
      if (a_pend) begin
        a_port  = m_acc1;
        a_wr    = m_acc1 ? p1_req_write : p0_req_write;
        a_addr  = m_acc1 ? p1_req_addr : p0_req_addr;
        a_wdata = m_acc1 ? p1_req_wdata : p0_req_wdata;
        a_err   = (a_addr >= AW'(MS));
        last_g  = m_acc1;
      end
    end
  end

  // ---------------- driver helpers (entered and left just after a rising edge) ----------------
  task automatic drive(input bit port, input bit v, input bit wr, input logic [63:0] addr,
                       input logic [63:0] wd);
    if (!port) begin
      p0_req_valid = v; p0_req_write = wr; p0_req_addr = addr; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_write = wr; p1_req_addr = addr; p1_req_wdata = wd;
    end
  endtask

  task automatic do_req(input bit port, input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output bit er, output int lat, output int wt);
    bit found;
    int acc_cyc;
    found = 1'b0;
    acc_cyc = 0;
    rd = '0; er = 1'b0; lat = -1; wt = -1;
    drive(port, 1'b1, wr, addr, wd);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((port ? p1_req_ready : p0_req_ready) === 1'b1) begin
        found = 1'b1; acc_cyc = cyc; wt = k;
        break;
      end
    end
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, '0, '0);
    if (!found) begin
      check("req_accept_timeout", 64'd0, 64'd1);
      return;
    end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((port ? p1_rsp_valid : p0_rsp_valid) === 1'b1) begin
        found = 1'b1;
        rd  = port ? p1_rsp_rdata : p0_rsp_rdata;
        er  = port ? p1_rsp_err : p0_rsp_err;
        lat = cyc - acc_cyc;
        break;
      end
    end
    @(posedge clk); #1;
    if (!found) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    bit          er;
    int          lat, wt, w0, r0, s0, gcount;
    bit          g_port [6];
    int          g_cyc [6];
    bit          rdy_seen [4];

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    check("reset_p0_rsp_valid", p0_rsp_valid, 0);
    check("reset_p1_rsp_valid", p1_rsp_valid, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_strobes", {mem_write, mem_read}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Port-0 store then load of address 5.
    w0 = wr_cnt;
    do_req(1'b0, 1'b1, 64'd5, 64'hDEAD_BEEF_0123_4567, rd, er, lat, wt);
    check("t1_store_err", er, 0);
    check("t1_store_rdata", rd, 0);
    check("t1_store_latency", lat, 2);
    check("t1_store_write_pulses", wr_cnt - w0, 1);
    r0 = rd_cnt;
    do_req(1'b0, 1'b0, 64'd5, 64'd0, rd, er, lat, wt);
    check("t1_load_rdata", rd, 64'hDEAD_BEEF_0123_4567);
    check("t1_load_err", er, 0);
    check("t1_load_latency", lat, 2);
    check("t1_load_read_pulses", rd_cnt - r0, 1);

    // Both ports contending: grants must alternate starting from port 0, every third cycle.
    do_reset();
    gcount = 0;
    drive(1'b0, 1'b1, 1'b0, 64'd10, 64'd0);
    drive(1'b1, 1'b1, 1'b1, 64'd10, 64'hA5A5_0000_0000_0000);
    for (int k = 0; k < 40 && gcount < 6; k++) begin
      @(negedge clk);
      if (p0_req_ready === 1'b1 || p1_req_ready === 1'b1) begin
        g_port[gcount] = p1_req_ready;
        g_cyc[gcount]  = cyc;
        gcount++;
      end
      @(posedge clk); #1;
      drive(1'b0, gcount < 6, 1'b0, 64'(10 + gcount), 64'd0);
      drive(1'b1, gcount < 6, 1'b1, 64'(10 + gcount), 64'hA5A5_0000_0000_0000 + 64'(gcount));
    end
    check("t2_grant_count", gcount, 6);
    for (int i = 0; i < gcount; i++) begin
      check("t2_grant_port", g_port[i], i % 2);
      if (i > 0) check("t2_grant_spacing", g_cyc[i] - g_cyc[i-1], 3);
    end
    repeat (3) @(posedge clk);
    #1;
`ifdef DMEM_ARB_PERF_EN
    do_req(1'b1, 1'b0, 64'd100, 64'd0, rd, er, lat, wt);
    check("perf_grant0", perf_grant0, 3);
    check("perf_grant1", perf_grant1, 4);
    check("perf_err", perf_err, 1);
    check("perf_conflict_nonzero", perf_conflict != 0, 1);
`endif

    // Out-of-range requests on port 1 never touch memory.
    do_req(1'b1, 1'b1, 64'd0, 64'h1111_0000, rd, er, lat, wt);
    do_req(1'b1, 1'b1, 64'd63, 64'h2222_0000, rd, er, lat, wt);
    w0 = wr_cnt; r0 = rd_cnt;
    do_req(1'b1, 1'b0, 64'd64, 64'd0, rd, er, lat, wt);
    check("t3_load64_err", er, 1);
    check("t3_load64_rdata", rd, 0);
    do_req(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBAD, rd, er, lat, wt);
    check("t3_storemax_err", er, 1);
    check("t3_storemax_rdata", rd, 0);
    check("t3_no_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
    do_req(1'b1, 1'b0, 64'd63, 64'd0, rd, er, lat, wt);
    check("t3_readback63", rd, 64'h2222_0000);
    do_req(1'b1, 1'b0, 64'd0, 64'd0, rd, er, lat, wt);
    check("t3_readback0", rd, 64'h1111_0000);

    // Reset landing in the ACCESS cycle of a store.
    drive(1'b0, 1'b1, 1'b1, 64'd3, 64'd7);
    wt = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (p0_req_ready === 1'b1) begin wt = k; break; end
    end
    check("t4_accepted", wt >= 0, 1);
    @(posedge clk); #1;
    w0 = wr_cnt; s0 = rsp_cnt;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t4_access_mem_write", mem_write, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_write", wr_cnt - w0, 0);
    check("t4_no_rsp", rsp_cnt - s0, 0);
    do_req(1'b0, 1'b0, 64'd3, 64'd0, rd, er, lat, wt);
    check("t4_idle_after_reset", wt, 0);
    check("t4_readback3", rd, 0);

    // Port 1 holds valid for four cycles; payload is only taken when ready.
    for (int k = 0; k < 4; k++) begin
      if (k == 0)      drive(1'b1, 1'b1, 1'b1, 64'd20, 64'hCAFE);
      else if (k < 3)  drive(1'b1, 1'b1, 1'b1, 64'd20, 64'hBAD0 + 64'(k));
      else             drive(1'b1, 1'b1, 1'b0, 64'd20, 64'd0);
      @(negedge clk);
      rdy_seen[k] = p1_req_ready;
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    check("t5_ready0", rdy_seen[0], 1);
    check("t5_ready1", rdy_seen[1], 0);
    check("t5_ready2", rdy_seen[2], 0);
    check("t5_ready3", rdy_seen[3], 1);
    rd = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (p1_rsp_valid === 1'b1) begin rd = p1_rsp_rdata; break; end
    end
    @(posedge clk); #1;
    check("t5_load_rdata", rd, 64'hCAFE);

    // Random traffic with occasional resets; the per-cycle model does the checking.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        bit held;
        int r;
        logic [63:0] a;
        held = (p == 0) ? (p0_req_valid && !m_acc0) : (p1_req_valid && !m_acc1);
        if (!held) begin
          r = $urandom_range(0, 9);
          if (r == 0)      a = 64'hFFFF_FFFF_FFFF_FFFF;
          else if (r == 1) a = 64'(64 + $urandom_range(0, 5));
          else             a = 64'($urandom_range(0, 63));
          drive(p[0], $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, a, {$urandom, $urandom});
        end
      end
      rst = ($urandom_range(0, 99) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 64x64 data memory between two requesters: port 0 is the datapath LDUR/STUR path and port 1 is the loader/debug port. It performs round-robin arbitration with a valid/ready handshake and bounds-checks the word address. It drives exactly one of MemRead/MemWrite per access and returns registered read data. It sits between the requesters and the data memory's Addr/Write_data/MemWrite/MemRead/ReadData pins.

Parameters:
DATA_W, 64, data width of requests and memory
ADDR_W, 64, requester and memory address width (word index)
MEMSIZE, 64, number of memory words; valid addresses are 0..MEMSIZE-1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (state cleared on a rising clk edge while rst==0)
p0_req_valid  in  1  port-0 request present
p0_req_ready  out  1  port-0 request accepted this cycle
p0_req_write  in  1  1=store, 0=load
p0_req_addr  in  ADDR_W  word address
p0_req_wdata  in  DATA_W  store data
p0_rsp_valid  out  1  one-cycle response pulse
p0_rsp_rdata  out  DATA_W  load data (0 for stores and errors)
p0_rsp_err  out  1  address out of range
p1_*  same set as p0_* for port 1
mem_addr  out  ADDR_W  to memory Addr
mem_wdata  out  DATA_W  to memory Write_data
mem_write  out  1  to memory MemWrite
mem_read  out  1  to memory MemRead
mem_rdata  in  DATA_W  from memory ReadData (asynchronous read)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE; last_grant resets to 1, so port 0 wins the first tie.
- IDLE: req_ready is combinational, asserted only for the winner. Winner rule:
  - Only one valid: that port wins.
  - Both valid: the port not equal to last_grant wins.
  - On acceptance: latch owner, write, addr, wdata and err=(addr>=MEMSIZE); update last_grant; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata come from the latched values.
  - mem_write = write & ~err; mem_read = ~write & ~err.
  - Never both high at once. On err, both stay 0 and memory is not touched.
  - On a load, mem_rdata is captured into rdata_q at the edge ending ACCESS. Stores and errors capture 0.
  - Next state: RESP.
- RESP (one cycle): owner's rsp_valid=1 with rsp_rdata=rdata_q and rsp_err=err. Other port's rsp_* are 0. Next state: IDLE.
- Latency and throughput:
  - Accept at cycle T, memory access at T+1, response at T+2. A store is committed at the edge ending T+1.
  - Next acceptance earliest at T+3.
- req_ready is 0 outside IDLE. Requesters hold valid and payload until ready.
- Outside ACCESS: mem_write=mem_read=0, mem_addr=0, mem_wdata=0.
- Reset value of every output is 0.
- mem_write and mem_read are additionally gated combinationally by rst, so no write commits in a cycle with rst==0, including reset asserted during ACCESS.
- Reset mid-operation: the FSM returns to IDLE, the in-flight response is dropped, and no rsp_valid is issued.
- No response backpressure: requesters must accept rsp_valid when it pulses.
- Address comparison is unsigned over the full ADDR_W; e.g. 64'hFFFF_FFFF_FFFF_FFFF is an error.

Optional Feature:
DMEM_ARB_PERF_EN:
- Defined: adds outputs perf_grant0, perf_grant1 (32-bit acceptance counts per port), perf_conflict (32-bit count of IDLE cycles with both valid) and perf_err (32-bit error count).
  - All counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist; arbitration and timing are identical.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - DATA_W/ADDR_W/MEMSIZE defaults
  - the request-struct typedef {write, addr, wdata}
- One natural sub-module, rr_arb2: two-input round-robin grant with last_grant register and a grant-enable input.
- The FSM and response muxing stay in dmem_arbiter.

Test Plan:
1. Port-0 store, then load: store addr 5 / data 64'hDEAD_BEEF_0123_4567, then load addr 5. Expect mem_write high for exactly 1 cycle at T+1, then p0_rsp_valid at T+2 with rdata=64'hDEAD_BEEF_0123_4567 and err=0.
2. Both ports valid every cycle for 6 grants (port 0 loads, port 1 stores). Expect grants alternating 0,1,0,1,0,1, first to port 0, with one acceptance every 3 cycles.
3. Port-1 load addr 64 and store addr 64'hFFFF_FFFF_FFFF_FFFF. Expect rsp_err=1 and rdata=0, mem_read/mem_write never asserted, and memory contents unchanged on readback.
4. Accept port-0 store addr 3 data 7, then drive rst=0 during the ACCESS cycle. Expect no mem_write pulse, no rsp_valid, and FSM in IDLE. A later load of addr 3 returns the prior value (0).
5. Port 1 holds valid alone for 4 cycles while port 0 idles. Expect p1_req_ready only in IDLE cycles and the payload sampled only on the accepting cycle.
6. (DMEM_ARB_PERF_EN) Run scenario 2 plus one error request. Expect perf_grant0=3, perf_grant1=4, perf_err=1, and perf_conflict nonzero.
